// File: rtl/rggen_rc_event_arbiter.sv
// Funnels per-requester event vectors into one read-clear status field and raises a
// coalesced interrupt from its value. Optional hold-off: RGGEN_RC_EVENT_ARBITER_HOLDOFF_EN.
module rggen_rc_event_arbiter #(
    parameter int REQUESTERS     = 4,
    parameter int WIDTH          = 8,
    parameter int HOLDOFF_CYCLES = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [REQUESTERS-1:0]         i_req_valid,
    output logic [REQUESTERS-1:0]         o_req_ready,
    input  logic [REQUESTERS*WIDTH-1:0]   i_req_bits,
    output logic [WIDTH-1:0]              o_set,
    output logic [$clog2(REQUESTERS)-1:0] o_grant_id,
    output logic                          o_set_valid,
    input  logic [WIDTH-1:0]              i_value,
    output logic                          o_irq
);
    localparam int ID_W = $clog2(REQUESTERS);
    localparam logic [ID_W:0]   REQ_COUNT = (ID_W+1)'(REQUESTERS);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(REQUESTERS - 1);

    logic [REQUESTERS-1:0] pend_v_r;
    logic [WIDTH-1:0]      pend_bits_r [REQUESTERS];
    logic [ID_W-1:0]       rr_ptr_r;
    logic                  grant_found_s;
    logic [ID_W-1:0]       grant_id_s;
    logic                  value_nz_s;

    assign o_req_ready = ~pend_v_r;
    assign value_nz_s  = (i_value != {WIDTH{1'b0}});

    // Round-robin search: first pending entry at or after rr_ptr, wrapping around.
    always_comb begin
        logic [ID_W:0] cand_v;
        grant_found_s = 1'b0;
        grant_id_s    = {ID_W{1'b0}};
        for (int i = 0; i < REQUESTERS; i++) begin
            cand_v = {1'b0, rr_ptr_r} + (ID_W+1)'(i);
            if (cand_v >= REQ_COUNT) begin
                cand_v = cand_v - REQ_COUNT;
            end else begin
                cand_v = cand_v;
            end
            if (!grant_found_s && pend_v_r[cand_v[ID_W-1:0]]) begin
                grant_found_s = 1'b1;
                grant_id_s    = cand_v[ID_W-1:0];
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Holding buffers, grant pointer and the registered set pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pend_v_r    <= {REQUESTERS{1'b0}};
            rr_ptr_r    <= {ID_W{1'b0}};
            o_set       <= {WIDTH{1'b0}};
            o_set_valid <= 1'b0;
            o_grant_id  <= {ID_W{1'b0}};
            for (int k = 0; k < REQUESTERS; k++) begin
                pend_bits_r[k] <= {WIDTH{1'b0}};
            end
        end else begin
            // A grant only touches a full buffer and a transfer only an empty one, so they never collide.
            for (int k = 0; k < REQUESTERS; k++) begin
                if (i_req_valid[k] && !pend_v_r[k]) begin
                    pend_v_r[k]    <= 1'b1;
                    pend_bits_r[k] <= i_req_bits[k*WIDTH +: WIDTH];
                end
            end
            if (grant_found_s) begin
                pend_v_r[grant_id_s] <= 1'b0;
                o_set                <= pend_bits_r[grant_id_s];
                o_set_valid          <= 1'b1;
                o_grant_id           <= grant_id_s;
                rr_ptr_r             <= (grant_id_s == LAST_ID) ? {ID_W{1'b0}} : grant_id_s + ID_W'(1);
            end else begin
                o_set       <= {WIDTH{1'b0}};
                o_set_valid <= 1'b0;
            end
        end
    end

`ifdef RGGEN_RC_EVENT_ARBITER_HOLDOFF_EN
    localparam int CNT_W = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLDOFF = 2'd1,
        ST_ASSERT  = 2'd2
    } irq_state_e;

    irq_state_e       state_r;
    irq_state_e       next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;

    // Interrupt next-state: the field must stay non-zero through the whole hold-off.
    always_comb begin
        next_state_s = state_r;
        cnt_nxt_s    = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (value_nz_s) begin
                    if (HOLDOFF_CYCLES == 0) begin
                        next_state_s = ST_ASSERT;
                    end else begin
                        next_state_s = ST_HOLDOFF;
                        cnt_nxt_s    = HOLD_LOAD;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_HOLDOFF: begin
                if (!value_nz_s) begin
                    next_state_s = ST_IDLE;
                end else if (cnt_r == {CNT_W{1'b0}}) begin
                    next_state_s = ST_ASSERT;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end
            end
            ST_ASSERT: begin
                if (!value_nz_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_ASSERT;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                cnt_nxt_s    = {CNT_W{1'b0}};
            end
        endcase
    end

    // Interrupt state, hold-off counter and registered interrupt.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            o_irq   <= 1'b0;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= cnt_nxt_s;
            o_irq   <= (next_state_s == ST_ASSERT);
        end
    end
`else
    localparam int unused_holdoff_cycles = HOLDOFF_CYCLES;

    // Without hold-off the interrupt is a registered OR of the field.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_irq <= 1'b0;
        end else begin
            o_irq <= value_nz_s;
        end
    end
`endif

endmodule

// File: tb/tb_rggen_rc_event_arbiter.sv
// Directed plus randomized bench for rggen_rc_event_arbiter against a behavioural model.
module tb_rggen_rc_event_arbiter;
    localparam int R = 4;
    localparam int W = 8;
    localparam int H = 4;
`ifdef RGGEN_RC_EVENT_ARBITER_HOLDOFF_EN
    localparam int IRQ_RUN = H + 1;
`else
    localparam int IRQ_RUN = 1;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [R-1:0]   req_valid = '0;
    logic [R-1:0]   req_ready;
    logic [R*W-1:0] req_bits = '0;
    logic [W-1:0]   set;
    logic [1:0]     grant_id;
    logic           set_valid;
    logic [W-1:0]   value = '0;
    logic           irq;

    int total = 0;
    int bad   = 0;

    // model state
    bit         m_pv [R];
    logic [W-1:0] m_pb [R];
    int         m_ptr = 0;
    logic [W-1:0] m_set = '0;
    bit         m_sv = 1'b0;
    int         m_gid = 0;
    int         m_run = 0;
    bit         m_irq = 1'b0;

    rggen_rc_event_arbiter #(.REQUESTERS(R), .WIDTH(W), .HOLDOFF_CYCLES(H)) dut (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_bits(req_bits), .o_set(set), .o_grant_id(grant_id), .o_set_valid(set_valid),
        .i_value(value), .o_irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge: advance the model from the inputs sampled at the edge, then compare.
    task automatic tick();
        int   g;
        int   k;
        bit   acc [R];
        logic [R-1:0] exp_ready;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < R; i++) begin
                m_pv[i] = 1'b0;
                m_pb[i] = '0;
            end
            m_ptr = 0; m_set = '0; m_sv = 1'b0; m_gid = 0; m_run = 0; m_irq = 1'b0;
        end else begin
            g = -1;
            for (int d = 0; d < R; d++) begin
                k = (m_ptr + d) % R;
                if (g < 0 && m_pv[k]) g = k;
            end
            for (int i = 0; i < R; i++) acc[i] = req_valid[i] && !m_pv[i];
            if (g >= 0) begin
                m_set = m_pb[g]; m_sv = 1'b1; m_gid = g; m_pv[g] = 1'b0; m_ptr = (g + 1) % R;
            end else begin
                m_set = '0; m_sv = 1'b0;
            end
            for (int i = 0; i < R; i++) begin
                if (acc[i]) begin
                    m_pv[i] = 1'b1;
                    m_pb[i] = req_bits[i*W +: W];
                end
            end
            if (value != '0) begin
                if (m_run < 1000) m_run++;
            end else begin
                m_run = 0;
            end
            m_irq = (m_run >= IRQ_RUN);
        end
        #1;
        for (int i = 0; i < R; i++) exp_ready[i] = !m_pv[i];
        check("set_valid", 32'(set_valid), 32'(m_sv));
        check("set", 32'(set), 32'(m_set));
        if (m_sv) check("grant_id", 32'(grant_id), 32'(m_gid));
        check("ready", 32'(req_ready), 32'(exp_ready));
        check("irq", 32'(irq), 32'(m_irq));
    endtask

    initial begin
        // Reset with every requester asserting valid.
        rst = 1'b1; req_valid = 4'b1111; req_bits = $urandom();
        tick(); tick();
        check("reset_ready", 32'(req_ready), 32'hF);
        check("reset_set_valid", 32'(set_valid), 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        rst = 1'b0; req_valid = '0;
        tick();

        // Single requester 2 sends A5.
        req_valid = 4'b0100; req_bits[2*W +: W] = 8'hA5;
        tick();
        check("r2_ready_low", 32'(req_ready[2]), 32'h0);
        req_valid = '0;
        tick();
        check("r2_pulse", 32'(set_valid), 32'h1);
        check("r2_bits", 32'(set), 32'hA5);
        check("r2_gid", 32'(grant_id), 32'h2);
        tick();
        check("r2_ready_back", 32'(req_ready[2]), 32'h1);
        check("r2_single_pulse", 32'(set_valid), 32'h0);

        // All four at once from rr_ptr = 0; requester 0 re-requests mid-sequence.
        rst = 1'b1; tick(); rst = 1'b0;
        req_valid = 4'b1111; req_bits = 32'h44_33_22_11;
        tick();
        req_valid = '0;
        tick();
        check("rr_g0", 32'(grant_id), 32'h0);
        req_valid = 4'b0001; req_bits[0 +: W] = 8'h55;
        tick();
        check("rr_g1", 32'(grant_id), 32'h1);
        req_valid = '0;
        tick();
        check("rr_g2", 32'(grant_id), 32'h2);
        tick();
        check("rr_g3", 32'(grant_id), 32'h3);
        tick();
        check("rr_g0_again", 32'(grant_id), 32'h0);
        check("rr_g0_bits", 32'(set), 32'h55);
        tick();

        // Hold-off aborted by a clear, then a full hold-off, read-clear and restart.
        value = 8'h10;
        repeat (3) tick();
        value = '0;
        repeat (3) tick();
        check("abort_irq", 32'(irq), 32'h0);
        value = 8'h03;
        repeat (7) tick();
        check("irq_high", 32'(irq), 32'h1);
        value = '0;
        tick();
        check("irq_cleared", 32'(irq), 32'h0);
        value = 8'h01;
        repeat (6) tick();
        value = '0;
        repeat (2) tick();

        // Reset while three buffers are pending.
        req_valid = 4'b1110; req_bits = $urandom();
        tick();
        req_valid = '0; rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("flush_ready", 32'(req_ready), 32'hF);
        check("flush_no_pulse", 32'(set_valid), 32'h0);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 99) == 0);
            req_valid = R'($urandom_range(0, 15));
            req_bits  = $urandom();
            if ($urandom_range(0, 7) == 0) value = ($urandom_range(0, 1) == 1) ? W'($urandom()) : '0;
            tick();
        end
        rst = 1'b0; req_valid = '0; value = '0;
        repeat (6) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
